// File: rtl/common_pkg.sv
// common_pkg: shared operand element type for the systolic array
package common_pkg;
    localparam int DATA_WIDTH = 16;
    typedef struct packed {
        logic                  enable;
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } matrix_data_t;
endpackage

// File: rtl/systolic_feeder_pkg.sv
// systolic_feeder_pkg: feeder FSM states and counter sizing helper
package systolic_feeder_pkg;
    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} feeder_state_t;
    function automatic int cnt_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/skew_line.sv
// skew_line: DELAY-deep shift register of matrix elements
module skew_line
    import common_pkg::*;
#(
    parameter int DELAY = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  matrix_data_t d_i,
    output matrix_data_t q_o
);
    matrix_data_t [DELAY-1:0] sr;
    // advance one stage per cycle; reset discards everything in flight
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) sr <= '0;
        else begin
            sr[0] <= d_i;
            for (int i = 1; i < DELAY; i++) sr[i] <= sr[i-1];
        end
    assign q_o = sr[DELAY-1];
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: skews operand vectors into LANES zero-filled streams for one PE edge
module systolic_feeder
    import common_pkg::*;
    import systolic_feeder_pkg::*;
#(
    parameter int LANES = 4,
    parameter int KW    = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic [KW-1:0]                 k_len_i,
    input  logic                          vec_valid_i,
    output logic                          vec_ready_o,
    input  logic [LANES*DATA_WIDTH-1:0]   vec_data_i,
    output matrix_data_t [LANES-1:0]      lane_o,
    output logic                          busy_o,
    output logic                          done_o
);
    localparam int FW = cnt_w(LANES);
    feeder_state_t            state;
    logic [KW-1:0]            k_len_q;
    logic [KW-1:0]            beat;
    logic [FW-1:0]            flush_cnt;
    logic                     accept;
    logic                     last_beat;
    matrix_data_t [LANES-1:0] lane_in;
    assign accept    = vec_valid_i & vec_ready_o;
    assign last_beat = beat == k_len_q - KW'(1);
    // non-accepted cycles inject all-zero bubbles so downstream PEs add nothing
    always_comb
        for (int i = 0; i < LANES; i++)
            lane_in[i] = accept ? matrix_data_t'{enable: 1'b1, last: last_beat,
                                                 data: vec_data_i[i*DATA_WIDTH +: DATA_WIDTH]} : '0;
    // pass sequencing: wait for start, stream k_len beats, then drain the skew
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            state       <= IDLE;
            k_len_q     <= '0;
            beat        <= '0;
            flush_cnt   <= '0;
            vec_ready_o <= 1'b0;
            busy_o      <= 1'b0;
        end else
            case (state)
                IDLE:
                    if (start_i && k_len_i != '0) begin
                        state       <= STREAM;
                        k_len_q     <= k_len_i;
                        beat        <= '0;
                        vec_ready_o <= 1'b1;
                        busy_o      <= 1'b1;
                    end
                STREAM:
                    if (accept) begin
                        beat <= beat + KW'(1);
                        if (last_beat) begin
                            state       <= FLUSH;
                            flush_cnt   <= '0;
                            vec_ready_o <= 1'b0;
                        end
                    end
                FLUSH:
                    if (flush_cnt == FW'(LANES-1)) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else flush_cnt <= flush_cnt + FW'(1);
                default: state <= IDLE;
            endcase
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        skew_line #(.DELAY(i + 1)) u_line (
            .clk_i(clk_i),
            .rst_i(rst_i),
            .d_i  (lane_in[i]),
            .q_o  (lane_o[i])
        );
    end
    // the final element leaving the deepest lane marks the end of the pass
    assign done_o = lane_o[LANES-1].last;
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: table-driven passes with a per-cycle lane/done scoreboard
module tb_systolic_feeder;
    import common_pkg::*;
    localparam int LANES = 4;
    localparam int KW    = 8;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        start = 1'b0;
    logic [KW-1:0]               k_len = '0;
    logic                        valid = 1'b0;
    logic [LANES*DATA_WIDTH-1:0] data = '0;
    logic                        ready;
    logic                        busy;
    logic                        done;
    matrix_data_t [LANES-1:0]    lane;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    matrix_data_t mon_e;

    typedef struct {
        int           cyc;
        int           lane;
        matrix_data_t v;
    } exp_t;
    exp_t sb[$];
    int   dq[$];

    typedef struct {
        int k;
        int gap;
        int base;
        bit flat;
        bit restart;
        int done_at;
    } pass_t;
    pass_t tbl[6];
    pass_t after_rst;

    systolic_feeder #(.LANES(LANES), .KW(KW)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .k_len_i    (k_len),
        .vec_valid_i(valid),
        .vec_ready_o(ready),
        .vec_data_i (data),
        .lane_o     (lane),
        .busy_o     (busy),
        .done_o     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk)
        if (mon_en) begin
            for (int i = 0; i < LANES; i++) begin
                mon_e = '0;
                for (int j = 0; j < sb.size(); j++)
                    if (sb[j].cyc == cyc && sb[j].lane == i) begin
                        mon_e = sb[j].v;
                        sb.delete(j);
                        break;
                    end
                chk($sformatf("lane%0d", i), 32'(lane[i]), 32'(mon_e));
            end
            chk("done", 32'(done), 32'(dq.size() != 0 && dq[0] == cyc));
            if (dq.size() != 0 && dq[0] == cyc) void'(dq.pop_front());
        end

    task automatic run_pass(input pass_t p);
        int s;
        logic [DATA_WIDTH-1:0] v;
        exp_t x;
        start = 1'b1;
        k_len = KW'(p.k);
        s = cyc;
        dq.push_back(s + p.done_at);
        step;
        start = 1'b0;
        chk("busy_on", 32'(busy), 32'(1));
        chk("ready_on", 32'(ready), 32'(1));
        for (int b = 0; b < p.k; b++) begin
            valid = 1'b1;
            for (int i = 0; i < LANES; i++) begin
                v = DATA_WIDTH'(p.flat ? p.base : p.base + 4 * b + i);
                data[i*DATA_WIDTH +: DATA_WIDTH] = v;
                x.cyc = cyc + 1 + i;
                x.lane = i;
                x.v.enable = 1'b1;
                x.v.last = (b == p.k - 1);
                x.v.data = v;
                sb.push_back(x);
            end
            if (p.restart && b == 0) begin
                start = 1'b1;
                k_len = KW'(p.k + 2);
            end
            step;
            start = 1'b0;
            valid = 1'b0;
            data = '1;
            if (b != p.k - 1) repeat (p.gap) step;
        end
        data = '0;
        while (cyc < s + p.done_at) step;
        chk("busy_at_done", 32'(busy), 32'(1));
        step;
        chk("busy_after", 32'(busy), 32'(0));
        chk("ready_after", 32'(ready), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{3, 0, 1, 1'b0, 1'b0, 7};
        tbl[1] = '{2, 1, 20, 1'b0, 1'b0, 7};
        tbl[2] = '{2, 0, 40, 1'b0, 1'b0, 6};
        tbl[3] = '{1, 0, 7, 1'b1, 1'b0, 5};
        tbl[4] = '{3, 0, 60, 1'b0, 1'b1, 7};
        tbl[5] = '{4, 2, 80, 1'b0, 1'b0, 14};
        after_rst = '{2, 0, 100, 1'b0, 1'b0, 6};

        repeat (3) step;
        for (int i = 0; i < LANES; i++) chk($sformatf("rst_lane%0d", i), 32'(lane[i]), 32'(0));
        chk("rst_ready", 32'(ready), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        rst = 1'b0;
        step;
        mon_en = 1'b1;

        start = 1'b1;
        k_len = '0;
        step;
        start = 1'b0;
        step;
        chk("kzero_busy", 32'(busy), 32'(0));
        chk("kzero_ready", 32'(ready), 32'(0));

        for (int n = 0; n < 6; n++) run_pass(tbl[n]);

        mon_en = 1'b0;
        start = 1'b1;
        k_len = KW'(3);
        step;
        start = 1'b0;
        valid = 1'b1;
        data = {16'd4, 16'd3, 16'd2, 16'd1};
        step;
        valid = 1'b0;
        data = '0;
        chk("pre_rst_lane0_en", 32'(lane[0].enable), 32'(1));
        chk("pre_rst_busy", 32'(busy), 32'(1));
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < LANES; i++) chk($sformatf("arst_lane%0d", i), 32'(lane[i]), 32'(0));
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_ready", 32'(ready), 32'(0));
        chk("arst_done", 32'(done), 32'(0));
        step;
        rst = 1'b0;
        step;
        mon_en = 1'b1;
        repeat (6) step;
        run_pass(after_rst);

        repeat (3) step;
        chk("sb_empty", 32'(sb.size()), 32'(0));
        chk("dq_empty", 32'(dq.size()), 32'(0));
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
